// File: rtl/fifo_sync_lvl_pkg.sv
// Shared read-mode names and parameter range checks for the level-aware FIFO family.
package fifo_sync_lvl_pkg;

    localparam string MODE_SHOWAHEAD = "SHOWAHEAD";
    localparam string MODE_NORMAL    = "NORMAL";

    // Thresholds must be reachable occupancies for a FIFO of depth 2^aw.
    function automatic bit thresholdsOk(input int aw, input int afullTh, input int aemptyTh);
        return (aw >= 1) &&
               (afullTh >= 1) && (afullTh <= (1 << aw)) &&
               (aemptyTh >= 0) && (aemptyTh <= (1 << aw) - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port, no reset.
module fifo_sync_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, flush,
// sticky overflow/underflow flags and a show-ahead or registered read port.
module fifo_sync_lvl
    import fifo_sync_lvl_pkg::*;
#(
    parameter int    AW        = 4,
    parameter int    DW        = 8,
    parameter string MODE      = "SHOWAHEAD",
    parameter int    AFULL_TH  = (1 << AW) - 2,
    parameter int    AEMPTY_TH = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          wr_i,
    input  logic [DW-1:0] din_i,
    input  logic          rd_i,
    output logic [DW-1:0] dout_o,
    output logic          dout_vld_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          afull_o,
    output logic          aempty_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    output logic          udf_o,
    input  logic          clr_err_i
);

    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AFULL_LVL  = AFULL_TH[AW:0];
    localparam logic [AW:0] AEMPTY_LVL = AEMPTY_TH[AW:0];

    if (!((MODE == MODE_SHOWAHEAD) || (MODE == MODE_NORMAL)) ||
        !thresholdsOk(AW, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("fifo_sync_lvl: invalid MODE or threshold parameters");
    end

    logic [AW:0]   wp_q, wp_d, rp_q, rp_d, count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wrAcc, rdAcc;
    logic [DW-1:0] ramRdata;

    // Pointers carry a wrap bit so equal low bits distinguish full from empty.
    assign empty_o  = (wp_q == rp_q);
    assign full_o   = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign wrAcc    = wr_i && !full_o && !flush_i;
    assign rdAcc    = rd_i && !empty_o && !flush_i;
    assign count_o  = count_q;
    assign afull_o  = (count_q >= AFULL_LVL);
    assign aempty_o = (count_q <= AEMPTY_LVL);
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (wrAcc) wp_d = wp_q + PTR_ONE;
            if (rdAcc) rp_d = rp_q + PTR_ONE;
            if (wrAcc && !rdAcc) begin
                count_d = count_q + PTR_ONE;
            end else if (rdAcc && !wrAcc) begin
                count_d = count_q - PTR_ONE;
            end
        end
        // A new error event outranks a simultaneous clear.
        if (wr_i && full_o && !flush_i) begin
            ovf_d = 1'b1;
        end else if (clr_err_i) begin
            ovf_d = 1'b0;
        end
        if (rd_i && empty_o && !flush_i) begin
            udf_d = 1'b1;
        end else if (clr_err_i) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_sync_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (wrAcc),
        .waddr_i(wp_q[AW-1:0]),
        .wdata_i(din_i),
        .raddr_i(rp_q[AW-1:0]),
        .rdata_o(ramRdata)
    );

    if (MODE == MODE_NORMAL) begin : g_normal
        logic [DW-1:0] dout_q;
        logic          dout_vld_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dout_q     <= '0;
                dout_vld_q <= 1'b0;
            end else begin
                dout_vld_q <= rdAcc;
                if (rdAcc) begin
                    dout_q <= ramRdata;
                end
            end
        end

        assign dout_o     = dout_q;
        assign dout_vld_o = dout_vld_q;
    end else begin : g_showahead
        assign dout_o     = ramRdata;
        assign dout_vld_o = !empty_o;
    end

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Drives a show-ahead and a normal-mode FIFO with the same stimulus and checks both
// against a queue-based reference model every cycle, plus directed literal checks.
module tb_fifo_sync_lvl;

    localparam int AW        = 2;
    localparam int DW        = 8;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = 2;
    localparam int AEMPTY_TH = 1;

    logic          clk = 1'b0;
    logic          rst, flush, wr, rd, clrErr;
    logic [DW-1:0] din;

    logic [DW-1:0] saDout, nmDout;
    logic          saVld, saFull, saEmpty, saAfull, saAempty, saOvf, saUdf;
    logic          nmVld, nmFull, nmEmpty, nmAfull, nmAempty, nmOvf, nmUdf;
    logic [AW:0]   saCount, nmCount;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    logic [DW-1:0] modelQ[$];
    bit            mOvf, mUdf, mVld;
    logic [DW-1:0] mDout;

    logic [DW-1:0] fillData [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    fifo_sync_lvl #(
        .AW(AW), .DW(DW), .MODE("SHOWAHEAD"), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dutSa (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_i(wr), .din_i(din), .rd_i(rd),
        .dout_o(saDout), .dout_vld_o(saVld), .full_o(saFull), .empty_o(saEmpty),
        .afull_o(saAfull), .aempty_o(saAempty), .count_o(saCount),
        .ovf_o(saOvf), .udf_o(saUdf), .clr_err_i(clrErr)
    );

    fifo_sync_lvl #(
        .AW(AW), .DW(DW), .MODE("NORMAL"), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dutNm (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_i(wr), .din_i(din), .rd_i(rd),
        .dout_o(nmDout), .dout_vld_o(nmVld), .full_o(nmFull), .empty_o(nmEmpty),
        .afull_o(nmAfull), .aempty_o(nmAempty), .count_o(nmCount),
        .ovf_o(nmOvf), .udf_o(nmUdf), .clr_err_i(clrErr)
    );

    // Reference model: a plain queue of stored words, decisions taken on pre-edge occupancy.
    always @(posedge clk) begin
        int sz;
        bit doRd, doWr;
        sz = modelQ.size();
        if (rst) begin
            modelQ.delete();
            mOvf  = 1'b0;
            mUdf  = 1'b0;
            mVld  = 1'b0;
            mDout = '0;
        end else if (flush) begin
            modelQ.delete();
            mVld = 1'b0;
            if (clrErr) begin
                mOvf = 1'b0;
                mUdf = 1'b0;
            end
        end else begin
            doRd = rd && (sz > 0);
            doWr = wr && (sz < DEPTH);
            if (wr && sz == DEPTH) mOvf = 1'b1;
            else if (clrErr)       mOvf = 1'b0;
            if (rd && sz == 0)     mUdf = 1'b1;
            else if (clrErr)       mUdf = 1'b0;
            mVld = doRd;
            if (doRd) mDout = modelQ.pop_front();
            if (doWr) modelQ.push_back(din);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int sz;
        sz = modelQ.size();
        cmp("sa.count",  32'(saCount),  sz);
        cmp("sa.empty",  32'(saEmpty),  32'(sz == 0));
        cmp("sa.full",   32'(saFull),   32'(sz == DEPTH));
        cmp("sa.afull",  32'(saAfull),  32'(sz >= AFULL_TH));
        cmp("sa.aempty", 32'(saAempty), 32'(sz <= AEMPTY_TH));
        cmp("sa.ovf",    32'(saOvf),    32'(mOvf));
        cmp("sa.udf",    32'(saUdf),    32'(mUdf));
        cmp("sa.vld",    32'(saVld),    32'(sz > 0));
        if (sz > 0) cmp("sa.dout", 32'(saDout), 32'(modelQ[0]));
        cmp("nm.count",  32'(nmCount),  sz);
        cmp("nm.empty",  32'(nmEmpty),  32'(sz == 0));
        cmp("nm.full",   32'(nmFull),   32'(sz == DEPTH));
        cmp("nm.afull",  32'(nmAfull),  32'(sz >= AFULL_TH));
        cmp("nm.aempty", 32'(nmAempty), 32'(sz <= AEMPTY_TH));
        cmp("nm.ovf",    32'(nmOvf),    32'(mOvf));
        cmp("nm.udf",    32'(nmUdf),    32'(mUdf));
        cmp("nm.vld",    32'(nmVld),    32'(mVld));
        cmp("nm.dout",   32'(nmDout),   32'(mDout));
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    // Inputs change on the falling edge; returns at the next falling edge.
    task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit r,
                                 input bit f, input bit c, input bit rs);
        wr     = w;
        din    = d;
        rd     = r;
        flush  = f;
        clrErr = c;
        rst    = rs;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; clrErr = 1'b0; din = '0;
        @(negedge clk);
        applyStimulus(0, 8'h00, 0, 0, 0, 1);
        checkEn = 1'b1;
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        cmp("rst.count", 32'(saCount), 0);
        cmp("rst.empty", 32'(saEmpty), 1);
        cmp("rst.aempty", 32'(saAempty), 1);
        cmp("rst.full", 32'(saFull), 0);
        cmp("rst.nmVld", 32'(nmVld), 0);
        cmp("rst.nmDout", 32'(nmDout), 0);

        for (int i = 0; i < 4; i++) applyStimulus(1, fillData[i], 0, 0, 0, 0);
        cmp("fill.count", 32'(saCount), 4);
        cmp("fill.full", 32'(saFull), 1);
        cmp("fill.afull", 32'(saAfull), 1);
        cmp("fill.saDout", 32'(saDout), 32'h11);

        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        cmp("rd1.nmVld", 32'(nmVld), 1);
        cmp("rd1.nmDout", 32'(nmDout), 32'h11);
        cmp("rd1.saDout", 32'(saDout), 32'h22);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 0, 0);
            cmp("rdN.nmDout", 32'(nmDout), 32'(fillData[i]));
        end
        cmp("drain.empty", 32'(saEmpty), 1);
        cmp("drain.aempty", 32'(saAempty), 1);

        for (int i = 0; i < 4; i++) applyStimulus(1, fillData[i], 0, 0, 0, 0);
        applyStimulus(1, 8'h55, 1, 0, 0, 0);
        cmp("fullWrRd.count", 32'(saCount), 3);
        cmp("fullWrRd.ovf", 32'(saOvf), 1);
        cmp("fullWrRd.saDout", 32'(saDout), 32'h22);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(1, 8'h66, 1, 0, 0, 0);
        cmp("emptyWrRd.count", 32'(saCount), 1);
        cmp("emptyWrRd.udf", 32'(saUdf), 1);
        cmp("emptyWrRd.saDout", 32'(saDout), 32'h66);
        cmp("emptyWrRd.nmVld", 32'(nmVld), 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        cmp("clr.ovf", 32'(saOvf), 0);
        cmp("clr.udf", 32'(saUdf), 0);

        applyStimulus(1, 8'hA0, 0, 0, 0, 0);
        applyStimulus(1, 8'hA1, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        cmp("nm.pulse1.vld", 32'(nmVld), 1);
        cmp("nm.pulse1.dout", 32'(nmDout), 32'hA0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        cmp("nm.pulse2.vld", 32'(nmVld), 1);
        cmp("nm.pulse2.dout", 32'(nmDout), 32'hA1);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        cmp("nm.noPulse.vld", 32'(nmVld), 0);
        cmp("nm.noPulse.udf", 32'(nmUdf), 1);
        cmp("nm.hold.dout", 32'(nmDout), 32'hA1);

        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, fillData[i], 0, 0, 0, 0);
        applyStimulus(1, 8'h5A, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(1, 8'h77, 0, 1, 0, 0);
        cmp("flush.count", 32'(saCount), 0);
        cmp("flush.empty", 32'(saEmpty), 1);
        cmp("flush.ovf", 32'(saOvf), 1);
        cmp("flush.nmVld", 32'(nmVld), 0);
        applyStimulus(1, 8'h99, 0, 0, 1, 0);
        cmp("postFlush.saDout", 32'(saDout), 32'h99);
        cmp("postFlush.ovf", 32'(saOvf), 0);
        cmp("postFlush.udf", 32'(saUdf), 0);

        applyStimulus(1, 8'h3C, 0, 0, 0, 0);
        applyStimulus(1, 8'hC3, 0, 0, 0, 1);
        cmp("midRst.count", 32'(saCount), 0);
        cmp("midRst.empty", 32'(saEmpty), 1);
        cmp("midRst.afull", 32'(saAfull), 0);
        cmp("midRst.nmDout", 32'(nmDout), 0);
        cmp("midRst.saVld", 32'(saVld), 0);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 50,
                          $urandom_range(99) < 2, $urandom_range(99) < 3,
                          $urandom_range(199) < 1);
        end

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
